glitch_filter: RTL and testbench
================================

Name: glitch_filter

Overview:
Downstream consumer of the periodic noise-injection stage. It takes the possibly-glitched single-bit serial signal and removes short spurious pulses. It only passes a level change after the new level has been stable for STABLE_CYCLES consecutive samples. It also reports clean edges and keeps a saturating count of rejected glitches, so the bench and system can measure how much noise the line carries.

Parameters:
STABLE_CYCLES, 3, consecutive identical samples needed to commit a new output level (legal range ≥2)
CNT_W, 8, width of the glitch counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
sig_in  input  1  noisy serial input, same clock domain as clk
en  input  1  filter enable; 0 = bypass
glitch_clr  input  1  synchronous clear of glitch_cnt
sig_out  output  1  filtered level (registered)
rise_pulse  output  1  one-cycle pulse when sig_out goes 0->1
fall_pulse  output  1  one-cycle pulse when sig_out goes 1->0
glitch_flag  output  1  one-cycle pulse per rejected glitch
glitch_cnt  output  CNT_W  saturating count of rejected glitches

Behaviour:
- Reset (rst=1 at an edge): in_q=0, sig_out=0, state=STABLE, run_cnt=0, rise_pulse=fall_pulse=glitch_flag=0, glitch_cnt=0. Reset overrides every other input, including mid-VERIFY.
- Input register: in_q <= sig_in on every edge. The FSM evaluates in_q only, never raw sig_in.
- Pulses (rise/fall/glitch_flag) default to 0 each cycle. Each is high exactly one cycle after its event edge.
- FSM when en=1:
  - STABLE: if in_q != sig_out, go to VERIFY with run_cnt <= 1. Otherwise stay.
  - VERIFY, in_q == sig_out (input reverted): this is a glitch. Go to STABLE, run_cnt <= 0, glitch_flag <= 1, increment glitch_cnt.
  - VERIFY, in_q != sig_out and run_cnt == STABLE_CYCLES-1: commit. sig_out <= in_q, assert rise_pulse or fall_pulse as appropriate, go to STABLE, run_cnt <= 0.
  - VERIFY, otherwise: run_cnt <= run_cnt+1.
- Latency: if sig_in first holds the new value at edge 0 and keeps it for STABLE_CYCLES samples (edges 0..N-1), sig_out changes at edge N.
- Glitch timing: a pulse of width W < N samples is rejected. glitch_flag is set at edge W+1.
- run_cnt width is clog2(STABLE_CYCLES)+1. It never exceeds STABLE_CYCLES-1.
- glitch_cnt:
  - Saturates at 2^CNT_W-1; no wrap.
  - glitch_clr=1 sets it to 0.
  - Clear wins over a simultaneous glitch event, giving 0.
  - glitch_flag still pulses on that event.
- Bypass (en=0):
  - state forced to STABLE, run_cnt <= 0.
  - sig_out <= in_q, so sig_out lags sig_in by 2 edges.
  - rise_pulse/fall_pulse still generated on sig_out changes.
  - No glitch detection; glitch_cnt holds, glitch_clr still honoured.
- en 1->0 during VERIFY: the pending candidate is dropped and not counted as a glitch. Bypass applies from that edge.
- en 0->1: filtering resumes from STABLE using the current sig_out.

Test Plan:
1. Reset/basic edge (N=3): hold rst=1 for 2 cycles with sig_in=1, then release and keep sig_in=1. Required: all outputs 0 during reset. sig_out rises at the 3rd edge after the first post-reset sample. rise_pulse is high for exactly 1 cycle. glitch_cnt stays 0.
2. Width threshold (N=3): with sig_out=0, drive 1-, 2- and 3-cycle high pulses on sig_in, separated by gaps of 10 cycles. Required: the 1- and 2-cycle pulses are rejected, each raising glitch_flag once (glitch_cnt=2). The 3-cycle pulse passes: sig_out is high for 3 cycles, with rise_pulse then fall_pulse.
3. Upstream chain: drive the noise stage with base signal 0, en=1, so it injects one 1-cycle high every 11 cycles, and feed its output here for 110 cycles. Required: sig_out stays 0 throughout, no rise/fall pulses, glitch_cnt=10.
4. Saturation/clear (CNT_W=2): inject 5 single-cycle glitches. Required: glitch_cnt sequence 1,2,3,3,3. Then assert glitch_clr on the same edge as a 6th glitch is detected. Required: glitch_cnt=0 and glitch_flag=1.
5. Bypass: set en=0 and drive a single-cycle high on sig_in. Required: sig_out is high for 1 cycle, 2 edges later. rise_pulse and fall_pulse each fire once. glitch_cnt is unchanged.
6. Reset mid-operation: raise sig_in, then assert rst at the edge where run_cnt=1 (VERIFY). Required: sig_out=0, no pulses, and the FSM is back in STABLE. After release with sig_in still 1, sig_out rises N edges later.

Source files
------------

// File: rtl/glitch_filter.sv
// glitch_filter: debounces a noisy single-bit serial line.
// A new level is committed only after STABLE_CYCLES identical registered
// samples. Clean edges are reported as pulses, and rejected glitches are
// counted in a saturating counter.
module glitch_filter #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  input  logic             glitch_clr,
  output logic             sig_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             glitch_flag,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int unsigned RUN_W = $clog2(STABLE_CYCLES) + 1;

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_VERIFY = 1'b1;

  logic             in_q;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_cnt_nxt;
  logic             sig_out_nxt;
  logic             glitch_evt;
  logic [CNT_W-1:0] glitch_cnt_nxt;

  // Input sample register; the FSM only ever looks at in_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= sig_in;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_STABLE;
      run_cnt     <= '0;
      sig_out     <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      glitch_flag <= 1'b0;
      glitch_cnt  <= '0;
    end else begin
      state       <= state_nxt;
      run_cnt     <= run_cnt_nxt;
      sig_out     <= sig_out_nxt;
      rise_pulse  <= sig_out_nxt & ~sig_out;
      fall_pulse  <= ~sig_out_nxt & sig_out;
      glitch_flag <= glitch_evt;
      glitch_cnt  <= glitch_cnt_nxt;
    end
  end

  // Next-state logic: verify a candidate level, or pass through in bypass.
  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    sig_out_nxt = sig_out;
    glitch_evt  = 1'b0;

    if (!en) begin
      // Bypass drops any pending candidate without counting it.
      state_nxt   = ST_STABLE;
      run_cnt_nxt = '0;
      sig_out_nxt = in_q;
    end else begin
      case (state)
        ST_STABLE: begin
          if (in_q != sig_out) begin
            state_nxt   = ST_VERIFY;
            run_cnt_nxt = RUN_ONE;
          end
        end
        ST_VERIFY: begin
          if (in_q == sig_out) begin
            state_nxt   = ST_STABLE;
            run_cnt_nxt = '0;
            glitch_evt  = 1'b1;
          end else if (run_cnt == RUN_LAST) begin
            state_nxt   = ST_STABLE;
            run_cnt_nxt = '0;
            sig_out_nxt = in_q;
          end else begin
            run_cnt_nxt = run_cnt + RUN_ONE;
          end
        end
        default: begin
          state_nxt   = ST_STABLE;
          run_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Saturating glitch counter; clear beats a simultaneous increment.
  always_comb begin
    glitch_cnt_nxt = glitch_cnt;
    if (glitch_clr) begin
      glitch_cnt_nxt = '0;
    end else if (glitch_evt && (glitch_cnt != CNT_MAX)) begin
      glitch_cnt_nxt = glitch_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_glitch_filter.sv
// tb_glitch_filter: directed, table-driven checks for glitch_filter with
// STABLE_CYCLES=3. A second instance with CNT_W=2 covers saturation.
module tb_glitch_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic       en;
  logic       glitch_clr;

  logic       so8, rp8, fp8, gf8;
  logic [7:0] cnt8;
  logic       so2, rp2, fp2, gf2;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  glitch_filter #(.STABLE_CYCLES(3), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .glitch_clr(glitch_clr),
    .sig_out(so8), .rise_pulse(rp8), .fall_pulse(fp8),
    .glitch_flag(gf8), .glitch_cnt(cnt8)
  );

  glitch_filter #(.STABLE_CYCLES(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .glitch_clr(glitch_clr),
    .sig_out(so2), .rise_pulse(rp2), .fall_pulse(fp2),
    .glitch_flag(gf2), .glitch_cnt(cnt2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       sin;
    logic       clr;
    logic       so;
    logic       rp;
    logic       fp;
    logic       gf;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic s, input logic c,
                     input logic xso, input logic xrp, input logic xfp,
                     input logic xgf, input logic [7:0] xcnt);
    vec_t v;
    v.rst = r; v.en = e; v.sin = s; v.clr = c;
    v.so = xso; v.rp = xrp; v.fp = xfp; v.gf = xgf; v.cnt = xcnt;
    tbl.push_back(v);
  endtask

  // Drive inputs away from the active edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic e, input logic s, input logic c);
    @(negedge clk);
    rst = r; en = e; sig_in = s; glitch_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int flags;
    rst = 1'b1; en = 1'b1; sig_in = 1'b0; glitch_clr = 1'b0;

    // Reset and basic rise: commit on the 3rd edge after the first sample.
    add(1,1,1,0, 0,0,0,0,0);
    add(1,1,1,0, 0,0,0,0,0);
    add(0,1,1,0, 0,0,0,0,0);
    add(0,1,1,0, 0,0,0,0,0);
    add(0,1,1,0, 0,0,0,0,0);
    add(0,1,1,0, 1,1,0,0,0);
    add(0,1,1,0, 1,0,0,0,0);
    add(0,1,1,0, 1,0,0,0,0);

    // Width threshold: 1- and 2-cycle pulses rejected, 3-cycle passes.
    add(1,1,0,0, 0,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0, 0,0,0,0,0);
    add(0,1,1,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,1,1);
    for (int i = 0; i < 10; i++) add(0,1,0,0, 0,0,0,0,1);
    add(0,1,1,0, 0,0,0,0,1);
    add(0,1,1,0, 0,0,0,0,1);
    add(0,1,0,0, 0,0,0,0,1);
    add(0,1,0,0, 0,0,0,1,2);
    for (int i = 0; i < 10; i++) add(0,1,0,0, 0,0,0,0,2);
    add(0,1,1,0, 0,0,0,0,2);
    add(0,1,1,0, 0,0,0,0,2);
    add(0,1,1,0, 0,0,0,0,2);
    add(0,1,0,0, 1,1,0,0,2);
    add(0,1,0,0, 1,0,0,0,2);
    add(0,1,0,0, 1,0,0,0,2);
    add(0,1,0,0, 0,0,1,0,2);
    for (int i = 0; i < 3; i++) add(0,1,0,0, 0,0,0,0,2);

    // Bypass: single-cycle pulse appears two edges later, count held.
    add(0,0,0,0, 0,0,0,0,2);
    add(0,0,0,0, 0,0,0,0,2);
    add(0,0,1,0, 0,0,0,0,2);
    add(0,0,0,0, 1,1,0,0,2);
    add(0,0,0,0, 0,0,1,0,2);
    add(0,0,0,0, 0,0,0,0,2);
    add(0,0,0,1, 0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0);

    // Enable drops mid-verify: candidate passes via bypass, no glitch counted.
    add(0,1,1,0, 0,0,0,0,0);
    add(0,1,1,0, 0,0,0,0,0);
    add(0,0,1,0, 1,1,0,0,0);
    add(0,0,0,0, 1,0,0,0,0);
    add(0,0,0,0, 0,0,1,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].sin, tbl[i].clr);
      chk("sig_out",     i, int'(so8),  int'(tbl[i].so));
      chk("rise_pulse",  i, int'(rp8),  int'(tbl[i].rp));
      chk("fall_pulse",  i, int'(fp8),  int'(tbl[i].fp));
      chk("glitch_flag", i, int'(gf8),  int'(tbl[i].gf));
      chk("glitch_cnt",  i, int'(cnt8), int'(tbl[i].cnt));
    end

    // Saturation with CNT_W=2: counts 1,2,3,3,3 then clear beats a glitch.
    step(1,1,0,0);
    for (int g = 0; g < 5; g++) begin
      step(0,1,1,0);
      step(0,1,0,0);
      step(0,1,0,0);
      chk("sat_flag", g, int'(gf2),  1);
      chk("sat_cnt",  g, int'(cnt2), (g < 3) ? g + 1 : 3);
      step(0,1,0,0);
      chk("sat_flag_low", g, int'(gf2), 0);
    end
    step(0,1,1,0);
    step(0,1,0,0);
    step(0,1,0,1);
    chk("clr_flag", 5, int'(gf2),  1);
    chk("clr_cnt",  5, int'(cnt2), 0);
    step(0,1,0,0);
    chk("clr_cnt_hold", 6, int'(cnt2), 0);

    // Upstream noise: one 1-cycle high every 11 cycles for 110 cycles.
    step(1,1,0,0);
    flags = 0;
    for (int i = 0; i < 110; i++) begin
      step(0,1,(i % 11) == 0,0);
      if (gf8) flags++;
      if (so8 || rp8 || fp8) begin
        chk("noise_quiet", i, int'({so8, rp8, fp8}), 0);
      end
    end
    for (int i = 0; i < 3; i++) step(0,1,0,0);
    chk("noise_sig_out", 0, int'(so8),  0);
    chk("noise_cnt",     0, int'(cnt8), 10);
    chk("noise_flags",   0, flags,      10);

    // Reset during VERIFY returns to idle; filtering restarts cleanly.
    step(1,1,0,0);
    step(0,1,0,0);
    step(0,1,0,0);
    step(0,1,1,0);
    step(0,1,1,0);
    step(1,1,1,0);
    chk("rst_sig_out", 0, int'(so8), 0);
    chk("rst_pulses",  0, int'({rp8, fp8, gf8}), 0);
    chk("rst_cnt",     0, int'(cnt8), 0);
    for (int i = 0; i < 3; i++) begin
      step(0,1,1,0);
      chk("post_rst_low", i, int'(so8), 0);
    end
    step(0,1,1,0);
    chk("post_rst_rise", 0, int'(so8), 1);
    chk("post_rst_rp",   0, int'(rp8), 1);
    step(0,1,1,0);
    chk("post_rst_rp_off", 0, int'(rp8), 0);
    chk("post_rst_flag",   0, int'(gf8), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
